nonce_scheduler: RTL and testbench
==================================

// Module: nonce_scheduler
// PURPOSE
//  Sequences the double-SHA256 core across a nonce range for one mining job. Sits between the
//  SPI register file (midstate/header/target/state/nonce) and the hash core: issues one nonce
//  per core transaction, compares each result against the target and reports the state byte
//  and nonce that the SPI side reads back.
// PARAMETERS
//  NONCE_W   32    nonce width; counter wraps modulo 2^NONCE_W
//  HASH_W    256   hash and target width
//  CNT_W     32    width of the completed-hash counter
// PORTS
//  CLK100MHZ        in   1        sole clock, all state on rising edge
//  reset            in   1        asynchronous, active-low; clears all state
//  start_i          in   1        1-cycle pulse: begin job (from register file after cs deasserts)
//  abort_i          in   1        1-cycle pulse: stop current job
//  nonce_base_i     in   NONCE_W  first nonce of range
//  nonce_last_i     in   NONCE_W  last nonce of range (inclusive)
//  target_i         in   HASH_W   target, unsigned, bit HASH_W-1 = MSB
//  core_start_o     out  1        1-cycle pulse: core latches core_nonce_o and begins
//  core_nonce_o     out  NONCE_W  nonce presented to core
//  core_abort_o     out  1        1-cycle pulse: core discards in-flight work
//  core_done_i      in   1        1-cycle pulse: core_hash_i valid
//  core_hash_i      in   HASH_W   final hash, same ordering as target_i
//  state_o          out  8        0 IDLE, 1 BUSY, 2 FOUND, 3 EXHAUSTED
//  nonce_o          out  NONCE_W  BUSY: nonce in flight; FOUND: winning nonce; else last value
//  solution_found_o out  1        high while state_o == FOUND
//  hash_count_o     out  CNT_W    completed hashes this job, saturating
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; target_q, nonce_cur, counter cleared.
//  - FSM: IDLE, ISSUE, WAIT, CMP, FOUND, EXHAUSTED. ISSUE/WAIT/CMP all report state_o = 1.
//  - start_i in IDLE/FOUND/EXHAUSTED: target_q <= target_i, nonce_cur <= nonce_base_i,
//    hash_count_o <= 0, solution_found_o <= 0 -> ISSUE. start_i while BUSY is ignored.
//  - ISSUE: core_start_o = 1 for exactly one cycle, core_nonce_o = nonce_cur -> WAIT.
//  - WAIT: hold until core_done_i; register core_hash_i, hash_count_o += 1 (saturate) -> CMP.
//    core_done_i in any other state is ignored.
//  - CMP: hit = (hash_q <= target_q), unsigned full width. hit -> FOUND, latch nonce_o.
//    miss and nonce_cur == nonce_last_i -> EXHAUSTED. else nonce_cur += 1 (wraps to 0) -> ISSUE.
//  - Issue-to-issue spacing = core latency + 3 cycles; core_start_o never asserts twice per done.
//  - nonce_last_i < nonce_base_i is legal: range runs through 2^NONCE_W-1 and wraps to 0.
//    nonce_base_i == nonce_last_i: exactly one hash.
//  - target_q is frozen for the job; register-file writes during BUSY have no effect on it.
//  - abort_i: from any state -> IDLE next cycle; core_abort_o pulses iff state was ISSUE/WAIT/CMP;
//    solution_found_o cleared. abort_i wins over simultaneous start_i and core_done_i.
//  - FOUND/EXHAUSTED are sticky until start_i, abort_i or reset.
//  - reset mid-job: immediate clear; core is reset on the same line.
// STRUCTURE
//  - miner_pkg: state codes (ST_IDLE=0, ST_BUSY=1, ST_FOUND=2, ST_EXHAUSTED=3),
//    NONCE_W/HASH_W defaults, FSM enum type.
//  - Sub-module target_compare: registered HASH_W unsigned <= compare, one cycle (CMP stage).
//  - Remainder (FSM, nonce counter, hash counter) lives in nonce_scheduler.
// TESTING  (core model: fixed 64-cycle latency; hash = 0 when nonce==9c9a4fcb, else all ones)
//  - Reset: reset low mid-WAIT -> all outputs 0, state_o 0 with no clock edge required.
//  - Hit: base 9c9a4fc0, last 9c9a4fff, target 00..0440C4<<168 -> state_o 2, nonce_o 9c9a4fcb,
//    hash_count_o 12, one core_start_o per core_done_i.
//  - Exhaust: base 00000010, last 00000013, no hit -> state_o 3, hash_count_o 4, nonce_o 00000013.
//  - Wrap: base fffffffe, last 00000001 -> nonces fffffffe,ffffffff,0,1 issued in order, state 3.
//  - Abort: abort_i with start_i in the same cycle during WAIT -> IDLE, core_abort_o 1 pulse,
//    late core_done_i ignored, hash_count_o unchanged.
//  - Target freeze/restart: change target_i mid-job -> result uses original target; start_i
//    in FOUND restarts with cleared counter and solution_found_o low.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared state codes, width defaults and FSM type for the nonce scheduler.
// Pure declarations and one helper; no logic, no latency, no flow control.
package miner_pkg;

  localparam int DEF_NONCE_W = 32;
  localparam int DEF_HASH_W  = 256;
  localparam int DEF_CNT_W   = 32;

  localparam logic [7:0] ST_IDLE      = 8'd0;
  localparam logic [7:0] ST_BUSY      = 8'd1;
  localparam logic [7:0] ST_FOUND     = 8'd2;
  localparam logic [7:0] ST_EXHAUSTED = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_FOUND,
    S_EXHAUSTED
  } fsm_t;

  // ISSUE/WAIT/CMP all present as BUSY and are the states with core work outstanding.
  function automatic logic is_busy(input fsm_t s);
    return (s == S_ISSUE) || (s == S_WAIT) || (s == S_CMP);
  endfunction

endpackage

// File: rtl/target_compare.sv
// Registered unsigned hash <= target compare, captured when en is high.
// Latency: 1 cycle from en to hit; no backpressure, result holds until the next en.
module target_compare #(
  parameter int HASH_W = 256
) (
  input  logic              core_clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              hit
);

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      hit <= 1'b0;
    end else if (en) begin
      hit <= (hash <= target);
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Walks a nonce range through the hash core one transaction at a time and reports the result.
// Latency: issue-to-issue is core latency + 3 cycles; the core is never issued again before its done.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int HASH_W  = DEF_HASH_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [NONCE_W-1:0] nonce_base_i,
  input  logic [NONCE_W-1:0] nonce_last_i,
  input  logic [HASH_W-1:0]  target_i,
  output logic               core_start_o,
  output logic [NONCE_W-1:0] core_nonce_o,
  output logic               core_abort_o,
  input  logic               core_done_i,
  input  logic [HASH_W-1:0]  core_hash_i,
  output logic [7:0]         state_o,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               solution_found_o,
  output logic [CNT_W-1:0]   hash_count_o
);

  fsm_t               st;
  logic [HASH_W-1:0]  target_q;
  logic [NONCE_W-1:0] nonce_cur;
  logic               hit;
  logic               cmp_en;

  // The compare runs on the arriving hash so its registered result is ready during CMP.
  assign cmp_en = (st == S_WAIT) && core_done_i && !abort_i;

  target_compare #(
    .HASH_W(HASH_W)
  ) u_cmp (
    .core_clk(CLK100MHZ),
    .arst_n  (reset),
    .en      (cmp_en),
    .hash    (core_hash_i),
    .target  (target_q),
    .hit     (hit)
  );

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      st               <= S_IDLE;
      target_q         <= '0;
      nonce_cur        <= '0;
      core_start_o     <= 1'b0;
      core_nonce_o     <= '0;
      core_abort_o     <= 1'b0;
      state_o          <= ST_IDLE;
      nonce_o          <= '0;
      solution_found_o <= 1'b0;
      hash_count_o     <= '0;
    end else begin
      core_start_o <= 1'b0;
      core_abort_o <= 1'b0;
      if (abort_i) begin
        core_abort_o     <= is_busy(st);
        st               <= S_IDLE;
        state_o          <= ST_IDLE;
        solution_found_o <= 1'b0;
      end else begin
        case (st)
          S_IDLE, S_FOUND, S_EXHAUSTED: begin
            if (start_i) begin
              target_q         <= target_i;
              nonce_cur        <= nonce_base_i;
              hash_count_o     <= '0;
              solution_found_o <= 1'b0;
              state_o          <= ST_BUSY;
              st               <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            core_start_o <= 1'b1;
            core_nonce_o <= nonce_cur;
            nonce_o      <= nonce_cur;
            st           <= S_WAIT;
          end
          S_WAIT: begin
            if (core_done_i) begin
              if (hash_count_o != {CNT_W{1'b1}}) begin
                hash_count_o <= hash_count_o + 1'b1;
              end
              st <= S_CMP;
            end
          end
          S_CMP: begin
            if (hit) begin
              nonce_o          <= nonce_cur;
              solution_found_o <= 1'b1;
              state_o          <= ST_FOUND;
              st               <= S_FOUND;
            end else if (nonce_cur == nonce_last_i) begin
              state_o <= ST_EXHAUSTED;
              st      <= S_EXHAUSTED;
            end else begin
              nonce_cur <= nonce_cur + 1'b1;
              st        <= S_ISSUE;
            end
          end
          default: begin
            state_o <= ST_IDLE;
            st      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a fixed-latency core model and a nonce scoreboard.
module tb_nonce_scheduler;
  import miner_pkg::*;

  localparam int          LAT = 64;
  localparam logic [31:0] WIN = 32'h9c9a4fcb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [31:0]  base = '0;
  logic [31:0]  last = '0;
  logic [255:0] target = '0;
  logic         core_start;
  logic [31:0]  core_nonce;
  logic         core_abort;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '1;
  logic [7:0]   state;
  logic [31:0]  nonce_o;
  logic         found;
  logic [31:0]  cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int starts = 0, dones = 0, aborts = 0;
  int cyc = 0, last_start = -1;
  logic [255:0] hit_target;

  nonce_scheduler dut (
    .CLK100MHZ       (clk),
    .reset           (rst_n),
    .start_i         (start),
    .abort_i         (abort),
    .nonce_base_i    (base),
    .nonce_last_i    (last),
    .target_i        (target),
    .core_start_o    (core_start),
    .core_nonce_o    (core_nonce),
    .core_abort_o    (core_abort),
    .core_done_i     (core_done),
    .core_hash_i     (core_hash),
    .state_o         (state),
    .nonce_o         (nonce_o),
    .solution_found_o(found),
    .hash_count_o    (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: latches on core_start, answers LAT cycles later; ignores core_abort.
  initial begin : core_model
    bit          busy = 1'b0;
    int          rem = 0;
    logic [31:0] lnonce = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      cyc++;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          rem--;
          if (rem == 0) begin
            core_done = 1'b1;
            core_hash = (lnonce == WIN) ? '0 : '1;
            busy = 1'b0;
            dones++;
          end
        end
        if (core_start) begin
          starts++;
          chk("one_start_per_done", {255'd0, busy}, 256'd0);
          checks++;
          assert (exp_q.size() > 0)
          else begin
            errors++;
            $error("FAIL unexpected_start observed=%0h expected=none", core_nonce);
          end
          if (exp_q.size() > 0) chk("issued_nonce", core_nonce, exp_q.pop_front());
          if (last_start >= 0) chk("issue_spacing", cyc - last_start, LAT + 3);
          last_start = cyc;
          busy = 1'b1;
          rem = LAT;
          lnonce = core_nonce;
        end
        if (core_abort) aborts++;
      end
    end
  end

  task automatic run_job(input logic [31:0] b, input logic [31:0] l, input logic [31:0] stop,
                         input logic [255:0] t);
    logic [31:0] n;
    n = b;
    forever begin
      exp_q.push_back(n);
      if (n == stop) break;
      n = n + 1;
    end
    @(negedge clk);
    base = b;
    last = l;
    target = t;
    last_start = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [7:0] code, input int budget);
    for (int i = 0; i < budget && state !== code; i++) @(negedge clk);
    chk(tag, state, code);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int s0, d0, a0;
    hit_target = 256'h0440C4 << 168;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", state, ST_IDLE);
    chk("rst_found", found, 0);
    chk("rst_count", cnt, 0);
    chk("rst_nonce", nonce_o, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_abort", core_abort, 0);
    rst_n = 1'b1;

    // Hit in the middle of the range
    s0 = starts;
    run_job(32'h9c9a4fc0, 32'h9c9a4fff, WIN, hit_target);
    wait_state("hit_state", ST_FOUND, 2000);
    chk("hit_nonce", nonce_o, WIN);
    chk("hit_found", found, 1);
    chk("hit_count", cnt, 12);
    chk("hit_starts", starts - s0, 12);
    repeat (100) @(negedge clk);
    chk("hit_sticky", state, ST_FOUND);
    chk("hit_no_extra_start", starts - s0, 12);
    chk("hit_queue_empty", exp_q.size(), 0);

    // Restart from FOUND, then widen target mid-job: original target must still apply
    run_job(32'h9c9a4fca, 32'h9c9a4fcd, WIN, hit_target);
    chk("restart_state", state, ST_BUSY);
    chk("restart_found", found, 0);
    chk("restart_count", cnt, 0);
    target = '1;
    wait_state("freeze_state", ST_FOUND, 500);
    chk("freeze_nonce", nonce_o, WIN);
    chk("freeze_count", cnt, 2);

    // Exhaust without a hit
    run_job(32'h00000010, 32'h00000013, 32'h00000013, hit_target);
    wait_state("exh_state", ST_EXHAUSTED, 600);
    chk("exh_count", cnt, 4);
    chk("exh_nonce", nonce_o, 32'h00000013);
    chk("exh_found", found, 0);

    // Range that wraps through zero
    run_job(32'hfffffffe, 32'h00000001, 32'h00000001, hit_target);
    wait_state("wrap_state", ST_EXHAUSTED, 600);
    chk("wrap_count", cnt, 4);
    chk("wrap_nonce", nonce_o, 32'h00000001);
    chk("wrap_queue_empty", exp_q.size(), 0);

    // Abort together with start during WAIT; the late done must be ignored
    s0 = starts;
    run_job(32'h00000100, 32'h000001ff, 32'h000001ff, hit_target);
    for (int i = 0; i < 20 && starts == s0; i++) @(negedge clk);
    chk("abort_first_issue", starts - s0, 1);
    repeat (10) @(negedge clk);
    a0 = aborts;
    d0 = dones;
    exp_q.delete();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_state", state, ST_IDLE);
    chk("abort_pulse", core_abort, 1);
    @(negedge clk);
    chk("abort_pulse_end", core_abort, 0);
    repeat (70) @(negedge clk);
    chk("abort_late_done_seen", dones - d0, 1);
    chk("abort_state_after_done", state, ST_IDLE);
    chk("abort_count", cnt, 0);
    chk("abort_pulses", aborts - a0, 1);
    chk("abort_no_restart", starts - s0, 1);

    // Abort from a sticky state must not touch the core
    run_job(32'h00000020, 32'h00000020, 32'h00000020, hit_target);
    wait_state("single_state", ST_EXHAUSTED, 200);
    chk("single_count", cnt, 1);
    a0 = aborts;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_state", state, ST_IDLE);
    chk("idle_abort_no_pulse", core_abort, 0);

    // Asynchronous reset in the middle of WAIT
    s0 = starts;
    run_job(32'h00000200, 32'h000002ff, 32'h000002ff, hit_target);
    for (int i = 0; i < 20 && starts == s0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, ST_IDLE);
    chk("arst_nonce", nonce_o, 0);
    chk("arst_core_nonce", core_nonce, 0);
    chk("arst_count", cnt, 0);
    chk("arst_found", found, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_stays_idle", state, ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
